serial_addsub: RTL and testbench

- Bit-serial adder/subtractor built on one full-adder/full-subtractor cell and a carry/borrow flip-flop.
- Computes a+b or a−b, processing one bit per clock, LSB first.
- It is the sequential counterpart to the combinational full_sub cell. It serves as a compact arithmetic unit for area-constrained datapaths.
- Operands are loaded in parallel. The result is returned in parallel with a done pulse.

---
 rtl/serial_addsub.sv | 110 +++++++++++
 tb/tb_serial_addsub.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/serial_addsub.sv
// serial_addsub: bit-serial adder/subtractor, one bit per clock, LSB first.
// A single full-adder/full-subtractor cell plus a carry/borrow flop walks the
// operands; the answer is presented in parallel with a one-cycle done pulse.
//
// Ports:
//   clk    rising-edge clock
//   rst    asynchronous active-high reset
//   start  request, sampled only in IDLE
//   mode   0 = a+b, 1 = a-b (sampled with start)
//   a, b   operands (sampled with start)
//   busy   high while in SHIFT or DONE
//   done   one-cycle pulse, result/cout valid
//   result sum or difference mod 2^WIDTH (holds until next completion)
//   cout   carry-out (add) or borrow-out (sub)
module serial_addsub #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout
);

  localparam int              CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0]   LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] sa, sb, sr;
  logic [CW-1:0]    cnt;
  logic             c, md;

  logic ai, bi, x, bit_o, c_nxt, load, step, last;

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_SHIFT;
      S_SHIFT: if (cnt == LAST) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // cell and control decode
  always_comb begin
    ai    = sa[0];
    bi    = sb[0];
    x     = ai ^ bi;
    bit_o = x ^ c;
    // add: generate | propagate&carry; sub: ~a&b borrows, equal bits pass borrow
    c_nxt = md ? ((~ai & bi) | (~x & c)) : ((ai & bi) | (x & c));
    load  = (state == S_IDLE) && start;
    step  = (state == S_SHIFT);
    last  = step && (cnt == LAST);
  end

  // datapath and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sa     <= '0;
      sb     <= '0;
      sr     <= '0;
      cnt    <= '0;
      c      <= 1'b0;
      md     <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= '0;
      cout   <= 1'b0;
    end else begin
      busy <= (state_nxt != S_IDLE);
      done <= last;
      if (load) begin
        sa  <= a;
        sb  <= b;
        md  <= mode;
        c   <= 1'b0;
        cnt <= '0;
      end else if (step) begin
        sa  <= sa >> 1;
        sb  <= sb >> 1;
        // enters at the MSB so bit 0 lands at the LSB after WIDTH shifts
        sr  <= {bit_o, sr[WIDTH-1:1]};
        c   <= c_nxt;
        cnt <= cnt + 1'b1;
      end
      // result only moves on completion; partial sums stay inside sr
      if (last) begin
        result <= {bit_o, sr[WIDTH-1:1]};
        cout   <= c_nxt;
      end
    end
  end

endmodule

// File: tb/tb_serial_addsub.sv
module tb_serial_addsub;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;

  logic         start8 = 1'b0, m8 = 1'b0;
  logic [W-1:0] a8 = '0, b8 = '0;
  logic         busy8, done8, co8;
  logic [W-1:0] res8;

  logic         start2 = 1'b0, m2 = 1'b0;
  logic [1:0]   a2 = '0, b2 = '0;
  logic         busy2, done2, co2;
  logic [1:0]   res2;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  serial_addsub #(.WIDTH(W)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .mode(m8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .result(res8), .cout(co8)
  );

  serial_addsub #(.WIDTH(2)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .mode(m2), .a(a2), .b(b2),
    .busy(busy2), .done(done2), .result(res2), .cout(co2)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // reference model: plain unsigned arithmetic
  function automatic logic [W:0] ref8(input logic m, input logic [W-1:0] x, input logic [W-1:0] y);
    logic [W-1:0] r;
    logic         co;
    if (m) begin r = x - y; co = (x < y); end
    else   begin r = x + y; co = ((int'(x) + int'(y)) >= (1 << W)); end
    return {co, r};
  endfunction

  task automatic op8(input logic m, input logic [W-1:0] x, input logic [W-1:0] y);
    logic [W:0] e;
    int lat, bc;
    e = ref8(m, x, y);
    @(negedge clk);
    start8 = 1'b1; m8 = m; a8 = x; b8 = y;
    @(posedge clk); #1;
    start8 = 1'b0;
    // scramble inputs: the operation must not see these
    a8 = W'($urandom); b8 = W'($urandom); m8 = ~m;
    chk("busy_on", busy8, 1);
    lat = 0; bc = 1;
    for (int j = 1; j <= W + 4; j++) begin
      @(posedge clk); #1;
      if (busy8) bc++;
      if (done8) begin lat = j; break; end
    end
    chk("latency", lat, W);
    chk("result", res8, e[W-1:0]);
    chk("cout", co8, e[W]);
    @(posedge clk); #1;
    chk("done_width", done8, 0);
    chk("busy_off", busy8, 0);
    chk("busy_cycles", bc, W + 1);
    @(posedge clk); #1;
    chk("result_hold", res8, e[W-1:0]);
  endtask

  task automatic op2(input logic m, input logic [1:0] x, input logic [1:0] y);
    logic [1:0] er;
    logic       ec;
    int lat;
    if (m) begin er = x - y; ec = (x < y); end
    else   begin er = x + y; ec = ((int'(x) + int'(y)) >= 4); end
    @(negedge clk);
    start2 = 1'b1; m2 = m; a2 = x; b2 = y;
    @(posedge clk); #1;
    start2 = 1'b0;
    lat = 0;
    for (int j = 1; j <= 6; j++) begin
      @(posedge clk); #1;
      if (done2) begin lat = j; break; end
    end
    chk("w2_latency", lat, 2);
    chk("w2_result", res2, er);
    chk("w2_cout", co2, ec);
    @(posedge clk); #1;
  endtask

  initial begin
    int d1, d2, nd;
    logic [W:0] e;

    // reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", busy8, 0);
    chk("rst_done", done8, 0);
    chk("rst_result", res8, 0);
    chk("rst_cout", co8, 0);
    @(negedge clk); rst = 1'b0;

    // directed cases
    op8(1'b0, 8'h3C, 8'h5A);
    op8(1'b0, 8'hFF, 8'h01);
    op8(1'b1, 8'h05, 8'h03);
    op8(1'b1, 8'h03, 8'h05);
    op8(1'b1, 8'h00, 8'hFF);
    op8(1'b0, 8'hFF, 8'hFF);

    // random cases
    for (int i = 0; i < 20; i++)
      op8(1'($urandom), W'($urandom), W'($urandom));

    // start re-pulsed during SHIFT and during DONE is ignored
    e = ref8(1'b0, 8'hC3, 8'h21);
    @(negedge clk);
    start8 = 1'b1; m8 = 1'b0; a8 = 8'hC3; b8 = 8'h21;
    @(posedge clk); #1;
    start8 = 1'b0;
    nd = 0;
    for (int j = 1; j <= W + 8; j++) begin
      @(negedge clk);
      if (j == 3 || j == W + 1) begin
        start8 = 1'b1; m8 = 1'b1; a8 = 8'h10; b8 = 8'h01;
      end
      @(posedge clk); #1;
      start8 = 1'b0;
      if (done8) nd++;
    end
    chk("ign_done_cnt", nd, 1);
    chk("ign_result", res8, e[W-1:0]);
    chk("ign_cout", co8, e[W]);
    chk("ign_busy", busy8, 0);

    // start held high: back-to-back operations every W+2 cycles
    @(negedge clk);
    start8 = 1'b1; m8 = 1'b0; a8 = 8'h11; b8 = 8'h22;
    @(posedge clk); #1;
    d1 = 0; d2 = 0;
    for (int j = 1; j <= 3 * W + 6; j++) begin
      @(posedge clk); #1;
      if (done8) begin
        if (d1 == 0) d1 = j;
        else begin d2 = j; break; end
      end
    end
    start8 = 1'b0;
    chk("hold_first", d1, W);
    chk("hold_period", d2 - d1, W + 2);
    chk("hold_result", res8, 8'h33);
    @(posedge clk); #1;
    chk("hold_idle", busy8, 0);

    // async reset mid-SHIFT after 4 bits
    @(negedge clk);
    start8 = 1'b1; m8 = 1'b0; a8 = 8'h77; b8 = 8'h19;
    @(posedge clk); #1;
    start8 = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_busy", busy8, 0);
    chk("arst_done", done8, 0);
    chk("arst_result", res8, 0);
    chk("arst_cout", co8, 0);
    @(negedge clk); rst = 1'b0;
    nd = 0;
    for (int j = 0; j < W + 4; j++) begin
      @(posedge clk); #1;
      if (done8 || busy8) nd++;
    end
    chk("arst_no_done", nd, 0);
    op8(1'b1, 8'h80, 8'h7F);

    // WIDTH=2 exhaustive
    for (int m = 0; m < 2; m++)
      for (int x = 0; x < 4; x++)
        for (int y = 0; y < 4; y++)
          op2(1'(m), 2'(x), 2'(y));

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
